// File: rtl/detector_round_ctrl.sv
// detector_round_ctrl
//   Runs one race at a time on the first-signal detector. It clears and arms
//   the detector, waits for the first arrival (with an optional timeout),
//   classifies the locked result and hands it to the host over valid/ready.
//   It also keeps a saturating win count for each channel.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start             round request, honoured only while idle
//   timeout_cyc       round timeout in cycles (0 = wait forever), taken at start
//   det_rst_n         active-low reset to the detector
//   det_y             detector locked output {c,b,a}
//   res_valid/ready   result handshake
//   res_winner        locked det_y of the round (000 on timeout)
//   res_status        00 single, 01 tie, 10 timeout
//   res_latency       ARMED cycles before detection (timeout_cyc on timeout)
//   busy              high whenever a round is in progress
//   cnt_clr           synchronous clear of the win counters
//   win_cnt_a/b/c     saturating per-channel win counts
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | detector held in reset, waiting for start
// CLEAR   | detector held in reset for two cycles before arming
// ARMED   | detector released, counting cycles until arrival or timeout
// REPORT  | result presented, detector stays locked until accepted
// HOLDOFF | detector back in reset for HOLDOFF cycles, then IDLE

module detector_round_ctrl #(
    parameter int TIMEOUT_W = 16,
    parameter int HOLDOFF   = 4,
    parameter int WIN_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TIMEOUT_W-1:0] timeout_cyc,
    output logic                 det_rst_n,
    input  logic [2:0]           det_y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2:0]           res_winner,
    output logic [1:0]           res_status,
    output logic [TIMEOUT_W-1:0] res_latency,
    output logic                 busy,
    input  logic                 cnt_clr,
    output logic [WIN_CNT_W-1:0] win_cnt_a,
    output logic [WIN_CNT_W-1:0] win_cnt_b,
    output logic [WIN_CNT_W-1:0] win_cnt_c
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [1:0] STAT_SINGLE  = 2'b00;
    localparam logic [1:0] STAT_TIE     = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARMED,
        ST_REPORT,
        ST_HOLDOFF
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0]   lat_q, lat_d;
    logic                   clr_cnt_q, clr_cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [2:0]             winner_q, winner_d;
    logic [1:0]             status_q, status_d;
    logic [TIMEOUT_W-1:0]   latency_q, latency_d;
    logic                   det_rst_n_q, det_rst_n_d;
    logic                   res_valid_q, res_valid_d;
    logic                   busy_q, busy_d;
    logic [WIN_CNT_W-1:0]   win_q [3];
    logic [WIN_CNT_W-1:0]   win_d [3];
    logic                   win_inc;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        clr_cnt_d = clr_cnt_q;
        hold_d    = hold_q;
        winner_d  = winner_q;
        status_d  = status_q;
        latency_d = latency_q;
        win_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tmo_d     = timeout_cyc;
                    clr_cnt_d = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q) begin
                    lat_d   = '0;
                    state_d = ST_ARMED;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            ST_ARMED: begin
                // Detection is tested first so it wins over a same-cycle timeout.
                if (det_y != 3'b000) begin
                    winner_d  = det_y;
                    latency_d = lat_q;
                    case (det_y)
                        3'b001, 3'b010, 3'b100: status_d = STAT_SINGLE;
                        default:                status_d = STAT_TIE;
                    endcase
                    win_inc = 1'b1;
                    state_d = ST_REPORT;
                end else if ((tmo_q != '0) && (lat_q == tmo_q - TIMEOUT_W'(1))) begin
                    winner_d  = 3'b000;
                    latency_d = tmo_q;
                    status_d  = STAT_TIMEOUT;
                    state_d   = ST_REPORT;
                end else if (lat_q != '1) begin
                    lat_d = lat_q + TIMEOUT_W'(1);
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    hold_d  = HOLD_W'(HOLDOFF - 1);
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        det_rst_n_d = (state_d == ST_ARMED) || (state_d == ST_REPORT);
        res_valid_d = (state_d == ST_REPORT);
        busy_d      = (state_d != ST_IDLE);

        for (int i = 0; i < 3; i++) begin
            win_d[i] = win_q[i];
            if (cnt_clr) begin
                win_d[i] = '0;
            end else if (win_inc && winner_d[i] && (win_q[i] != '1)) begin
                win_d[i] = win_q[i] + WIN_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            lat_q       <= '0;
            clr_cnt_q   <= 1'b0;
            hold_q      <= '0;
            winner_q    <= 3'b000;
            status_q    <= STAT_SINGLE;
            latency_q   <= '0;
            det_rst_n_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            lat_q       <= lat_d;
            clr_cnt_q   <= clr_cnt_d;
            hold_q      <= hold_d;
            winner_q    <= winner_d;
            status_q    <= status_d;
            latency_q   <= latency_d;
            det_rst_n_q <= det_rst_n_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            for (int i = 0; i < 3; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign det_rst_n   = det_rst_n_q;
    assign res_valid   = res_valid_q;
    assign res_winner  = winner_q;
    assign res_status  = status_q;
    assign res_latency = latency_q;
    assign busy        = busy_q;
    assign win_cnt_a   = win_q[0];
    assign win_cnt_b   = win_q[1];
    assign win_cnt_c   = win_q[2];

endmodule

// File: tb/tb_detector_round_ctrl.sv
// Testbench for detector_round_ctrl: directed rounds from the test plan
// followed by randomized rounds, all compared against a round-level model.

module tb_detector_round_ctrl;

    localparam int TW      = 16;
    localparam int HOLD    = 4;
    localparam int WCW     = 2;
    localparam int CNT_MAX = (1 << WCW) - 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic [TW-1:0]   timeout_cyc;
    logic            det_rst_n;
    logic [2:0]      det_y;
    logic            res_valid;
    logic            res_ready;
    logic [2:0]      res_winner;
    logic [1:0]      res_status;
    logic [TW-1:0]   res_latency;
    logic            busy;
    logic            cnt_clr;
    logic [WCW-1:0]  win_cnt_a;
    logic [WCW-1:0]  win_cnt_b;
    logic [WCW-1:0]  win_cnt_c;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt[3];

    detector_round_ctrl #(
        .TIMEOUT_W (TW),
        .HOLDOFF   (HOLD),
        .WIN_CNT_W (WCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .timeout_cyc (timeout_cyc),
        .det_rst_n   (det_rst_n),
        .det_y       (det_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_winner  (res_winner),
        .res_status  (res_status),
        .res_latency (res_latency),
        .busy        (busy),
        .cnt_clr     (cnt_clr),
        .win_cnt_a   (win_cnt_a),
        .win_cnt_b   (win_cnt_b),
        .win_cnt_c   (win_cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt_a"}, 32'(win_cnt_a), 32'(exp_cnt[0]));
        check({tag, "_cnt_b"}, 32'(win_cnt_b), 32'(exp_cnt[1]));
        check({tag, "_cnt_c"}, 32'(win_cnt_c), 32'(exp_cnt[2]));
    endtask

    // One full round. arr < 0 means the detector never fires.
    task automatic run_round(input int n, input int arr, input logic [2:0] val,
                             input int rdy_dly, input bit early_rdy,
                             input bit clr_on_win, input bit start_in_rpt);
        int         d;
        logic [2:0] ew;
        int         es;
        int         el;
        int         k;
        bit         got;

        // Expected outcome from the round rules alone.
        if (arr >= 0 && (n == 0 || arr < n)) begin
            d  = arr;
            ew = val;
            el = arr;
            es = ($countones(val) == 1) ? 0 : 1;
        end else begin
            d  = n - 1;
            ew = 3'b000;
            el = n;
            es = 2;
        end

        check("idle_busy", 32'(busy), 32'd0);
        timeout_cyc = TW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        timeout_cyc = TW'($urandom);
        check("clr1_rstn", 32'(det_rst_n), 32'd0);
        check("clr1_busy", 32'(busy), 32'd1);
        tick();
        check("clr2_rstn", 32'(det_rst_n), 32'd0);
        tick();
        check("armed_rstn", 32'(det_rst_n), 32'd1);

        k   = 0;
        got = 1'b0;
        res_ready = early_rdy;
        while (!got && k < 400) begin
            det_y   = (arr >= 0 && k >= arr) ? val : 3'b000;
            cnt_clr = clr_on_win && (k == d);
            tick();
            cnt_clr = 1'b0;
            if (res_valid) got = 1'b1;
            else           k++;
        end
        check("valid_cycle", got ? 32'(k) : 32'hFFFF_FFFF, 32'(d));
        if (!got) begin
            res_ready = 1'b0;
            det_y = 3'b000;
            return;
        end

        for (int i = 0; i < 3; i++) begin
            if (clr_on_win)                      exp_cnt[i] = 0;
            else if (ew[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i] = exp_cnt[i] + 1;
        end
        check("winner",  32'(res_winner),  32'(ew));
        check("status",  32'(res_status),  32'(es));
        check("latency", 32'(res_latency), 32'(el));
        check_counters("win");

        res_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            if (start_in_rpt && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            check("hold_valid",   32'(res_valid),   32'd1);
            check("hold_winner",  32'(res_winner),  32'(ew));
            check("hold_status",  32'(res_status),  32'(es));
            check("hold_latency", 32'(res_latency), 32'(el));
            check("hold_busy",    32'(busy),        32'd1);
            check("hold_rstn",    32'(det_rst_n),   32'd1);
        end

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        det_y = 3'b000;
        for (int i = 0; i < HOLD; i++) begin
            check("holdoff_busy",  32'(busy),      32'd1);
            check("holdoff_valid", 32'(res_valid), 32'd0);
            check("holdoff_rstn",  32'(det_rst_n), 32'd0);
            tick();
        end
        check("idle_after_holdoff", 32'(busy),      32'd0);
        check("idle_rstn",          32'(det_rst_n), 32'd0);
        tick();
        check("no_queued_start", 32'(busy), 32'd0);
    endtask

    // Reset asserted between clock edges while in ARMED or REPORT.
    task automatic reset_mid_round(input bit in_report);
        timeout_cyc = TW'(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        if (in_report) begin
            det_y = 3'b100;
            tick();
            check("pre_rst_valid", 32'(res_valid), 32'd1);
        end else begin
            tick();
            tick();
            check("pre_rst_armed", 32'(det_rst_n), 32'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid",  32'(res_valid),  32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_rstn",   32'(det_rst_n),  32'd0);
        check("rst_winner", 32'(res_winner), 32'd0);
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        check_counters("rst");
        #3;
        rst = 1'b0;
        det_y = 3'b000;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int arr;
        int dly;
        logic [2:0] val;

        rst = 1'b1;
        start = 1'b0;
        timeout_cyc = '0;
        det_y = 3'b000;
        res_ready = 1'b0;
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();

        check("reset_rstn",    32'(det_rst_n),   32'd0);
        check("reset_valid",   32'(res_valid),   32'd0);
        check("reset_winner",  32'(res_winner),  32'd0);
        check("reset_status",  32'(res_status),  32'd0);
        check("reset_latency", 32'(res_latency), 32'd0);
        check("reset_busy",    32'(busy),        32'd0);
        check_counters("reset");

        run_round(100, 5, 3'b010, 0, 1'b0, 1'b0, 1'b0);
        run_round(0,   0, 3'b101, 0, 1'b0, 1'b0, 1'b0);
        run_round(8,  -1, 3'b000, 0, 1'b0, 1'b0, 1'b0);
        run_round(8,   7, 3'b001, 0, 1'b0, 1'b0, 1'b0);
        run_round(3,   1, 3'b010, 20, 1'b0, 1'b0, 1'b1);

        repeat (4) run_round(0, 2, 3'b001, 0, 1'b1, 1'b0, 1'b0);
        check("sat_a", 32'(win_cnt_a), 32'(CNT_MAX));

        run_round(10, 3, 3'b111, 1, 1'b0, 1'b1, 1'b0);
        check("clr_a", 32'(win_cnt_a), 32'd0);
        check("clr_b", 32'(win_cnt_b), 32'd0);
        check("clr_c", 32'(win_cnt_c), 32'd0);

        reset_mid_round(1'b0);
        reset_mid_round(1'b1);
        run_round(6, 2, 3'b100, 0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 20);
            if (n == 0)                         arr = $urandom_range(0, 25);
            else if ($urandom_range(0, 3) == 0) arr = -1;
            else                                arr = $urandom_range(0, n + 3);
            val = 3'($urandom_range(1, 7));
            dly = $urandom_range(0, 3);
            run_round(n, arr, val, dly, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), (dly > 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
